// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared debug-path types and latch select list
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } state_e;

  localparam int SEL_COUNT      = 19;
  localparam int BYTES_PER_WORD = 4;

  // Every defined latch code, in dump order; unlisted codes are never driven.
  localparam logic [6:0] SEL_LIST [0:SEL_COUNT-1] = '{
    7'h00, 7'h01,
    7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15,
    7'h20, 7'h21, 7'h23, 7'h24, 7'h25,
    7'h30, 7'h31, 7'h32, 7'h33,
    7'h40, 7'h41
  };

  // Pick byte n of a word in transmit order; msb_first puts bits [31:24] at n=0.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] n,
                                           input logic msb_first);
    logic [1:0] k;
    k = msb_first ? ~n : n;
    return w[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/latch_dump.sv
// rtl/latch_dump.sv - steps the latch mux through every code and streams the words as bytes
module latch_dump
  import debug_pkg::*;
#(
  parameter logic MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] mux_data,
  input  logic        tx_ready,
  output logic [6:0]  mux_sel,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] LAST_IDX  = 5'(SEL_COUNT - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_e      state_q;
  logic [4:0]  idx_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;
  logic [6:0]  mux_sel_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        busy_q;
  logic        done_q;

  // Dump sequencer: select a code, let the mux register it, capture, then drain four bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      mux_sel_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q     <= '0;
            mux_sel_q <= SEL_LIST[0];
            busy_q    <= 1'b1;
            state_q   <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          word_q     <= mux_data;
          byte_cnt_q <= '0;
          tx_data_q  <= word_byte(mux_data, 2'd0, MSB_FIRST);
          tx_valid_q <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_valid_q && tx_ready) begin
            if (byte_cnt_q != LAST_BYTE) begin
              tx_data_q  <= word_byte(word_q, byte_cnt_q + 2'd1, MSB_FIRST);
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end else begin
              tx_valid_q <= 1'b0;
              if (idx_q != LAST_IDX) begin
                idx_q     <= idx_q + 5'd1;
                mux_sel_q <= SEL_LIST[idx_q + 5'd1];
                state_q   <= ST_SELECT;
              end else begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mux_sel  = mux_sel_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_latch_dump.sv
// tb/tb_latch_dump.sv - scoreboard bench for latch_dump, MSB-first and LSB-first instances
module tb_latch_dump;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] mux_data_m = '0;
  logic [31:0] mux_data_l = '0;
  logic [6:0]  sel_m, sel_l;
  logic [7:0]  txd_m, txd_l;
  logic        v_m, v_l, b_m, b_l, d_m, d_l;

  always #5 clk = ~clk;

  latch_dump #(.MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .start(start), .mux_data(mux_data_m), .tx_ready(tx_ready),
    .mux_sel(sel_m), .tx_data(txd_m), .tx_valid(v_m), .busy(b_m), .done(d_m)
  );

  latch_dump #(.MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .start(start), .mux_data(mux_data_l), .tx_ready(tx_ready),
    .mux_sel(sel_l), .tx_data(txd_l), .tx_valid(v_l), .busy(b_l), .done(d_l)
  );

  // Registered latch mux models
  always @(posedge clk) mux_data_m <= {25'd0, sel_m};
  always @(posedge clk) mux_data_l <= (sel_l == 7'h10) ? 32'hA1B2C3D4 : {25'd0, sel_l};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];
  int bytes_m = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;

  logic [6:0] codes [0:18] = '{
    7'h00, 7'h01, 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15,
    7'h20, 7'h21, 7'h23, 7'h24, 7'h25, 7'h30, 7'h31, 7'h32, 7'h33, 7'h40, 7'h41
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_dump();
    logic [31:0] wm, wl;
    for (int i = 0; i < 19; i++) begin
      wm = {25'd0, codes[i]};
      wl = (codes[i] == 7'h10) ? 32'hA1B2C3D4 : wm;
      exp_m.push_back(wm[31:24]); exp_m.push_back(wm[23:16]);
      exp_m.push_back(wm[15:8]);  exp_m.push_back(wm[7:0]);
      exp_l.push_back(wl[7:0]);   exp_l.push_back(wl[15:8]);
      exp_l.push_back(wl[23:16]); exp_l.push_back(wl[31:24]);
    end
  endtask

  // Byte monitor, hold-stability checks and done counting, all away from the rising edge
  always @(negedge clk) begin
    if (v_m && tx_ready) begin
      if (exp_m.size() == 0) chk("extra_byte_msb", 32'd1, 32'd0);
      else chk("byte_msb", {24'd0, txd_m}, {24'd0, exp_m.pop_front()});
      bytes_m++;
    end
    if (v_l && tx_ready) begin
      if (exp_l.size() == 0) chk("extra_byte_lsb", 32'd1, 32'd0);
      else chk("byte_lsb", {24'd0, txd_l}, {24'd0, exp_l.pop_front()});
    end
    if (pv && !pr) begin
      chk("hold_valid", {31'd0, v_m}, 32'd1);
      chk("hold_data", {24'd0, txd_m}, {24'd0, pd});
    end
    pv = v_m;
    pr = tx_ready;
    pd = txd_m;
    if (d_m) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  typedef struct {
    string name;
    int    pct;
    int    restart_at;
    int    stuck;
    bit    chk_lat;
  } vec_t;

  function automatic logic rdy(input int pct);
    return ($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0;
  endfunction

  task automatic run_dump(input vec_t v);
    int c0, n, held;
    push_dump();
    done_cnt = 0;
    bytes_m = 0;
    @(posedge clk); #1;
    start = 1'b1;
    tx_ready = (v.stuck > 0) ? 1'b0 : rdy(v.pct);
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    chk({v.name, "_busy_e0"}, {31'd0, b_m}, 32'd1);
    chk({v.name, "_sel_e0"}, {25'd0, sel_m}, 32'd0);
    if (v.stuck > 0) begin
      n = 0;
      while (!v_m && n < 50) begin @(posedge clk); #1; n++; end
      held = 0;
      repeat (v.stuck) begin
        @(posedge clk); #1;
        if (v_m && b_m) held++;
      end
      chk({v.name, "_stuck_held"}, held, v.stuck);
    end
    n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(posedge clk); #1;
      tx_ready = rdy(v.pct);
      start = (n == v.restart_at) ? 1'b1 : 1'b0;
      n++;
    end
    start = 1'b0;
    tx_ready = 1'b1;
    if (done_cnt == 0) chk({v.name, "_timeout"}, 32'd0, 32'd1);
    if (v.chk_lat) chk({v.name, "_done_cycle"}, done_cyc - c0, 32'd114);
    repeat (4) @(posedge clk);
    #1;
    chk({v.name, "_done_once"}, done_cnt, 32'd1);
    chk({v.name, "_idle_after"}, {31'd0, b_m}, 32'd0);
    chk({v.name, "_byte_count"}, bytes_m, 32'd76);
    chk({v.name, "_queue_empty"}, exp_m.size() + exp_l.size(), 32'd0);
  endtask

  initial begin
    vec_t vecs [4];
    int n;
    vecs[0] = '{name: "ideal",       pct: 100, restart_at: -1, stuck: 0,    chk_lat: 1'b1};
    vecs[1] = '{name: "backpress",   pct: 30,  restart_at: -1, stuck: 0,    chk_lat: 1'b0};
    vecs[2] = '{name: "start_busy",  pct: 100, restart_at: 40, stuck: 0,    chk_lat: 1'b1};
    vecs[3] = '{name: "stuck_sink",  pct: 100, restart_at: -1, stuck: 1000, chk_lat: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", {25'd0, sel_m}, 32'd0);
    chk("rst_data", {24'd0, txd_m}, 32'd0);
    chk("rst_valid", {31'd0, v_m}, 32'd0);
    chk("rst_busy", {31'd0, b_m}, 32'd0);
    chk("rst_done", {31'd0, d_m}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) run_dump(vecs[i]);

    // Asynchronous reset in the middle of a dump, right after byte 30 transfers
    push_dump();
    bytes_m = 0;
    @(posedge clk); #1;
    start = 1'b1;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (bytes_m < 30 && n < 500) begin @(posedge clk); n++; end
    chk("midrst_reached_30", bytes_m, 32'd30);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_sel", {25'd0, sel_m}, 32'd0);
    chk("midrst_data", {24'd0, txd_m}, 32'd0);
    chk("midrst_valid", {31'd0, v_m}, 32'd0);
    chk("midrst_busy", {31'd0, b_m}, 32'd0);
    chk("midrst_done", {31'd0, d_m}, 32'd0);
    chk("midrst_valid_lsb", {31'd0, v_l}, 32'd0);
    exp_m.delete();
    exp_l.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_autostart", {31'd0, b_m}, 32'd0);
    run_dump(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
